// File: rtl/adc_trig_capture_if.sv
// adc_trig_capture_if: ADC sample input and FIFO write-side bundle for adc_trig_capture.
interface adc_trig_capture_if #(
   parameter int NCH  = 2,
   parameter int DW   = 14,
   parameter int TS_W = 40
);
   logic [NCH*DW-1:0] adc_data;
   logic              adc_valid;
   logic              fifo_full;
   logic [NCH*DW-1:0] out_data;
   logic              out_valid;
   logic              out_first;
   logic              out_last;
   logic [TS_W-1:0]   out_ts;
   modport master (output adc_data, adc_valid, fifo_full,
                   input  out_data, out_valid, out_first, out_last, out_ts);
   modport slave  (input  adc_data, adc_valid, fifo_full,
                   output out_data, out_valid, out_first, out_last, out_ts);
endinterface

// File: rtl/adc_trig_capture.sv
// adc_trig_capture: multi-channel triggered ADC capture with pre-trigger delay line,
// external/threshold triggering, per-event timestamp and drop accounting.
module adc_trig_capture #(
   parameter  int NCH       = 2,
   parameter  int DW        = 14,
   parameter  int PRE_DEPTH = 16,
   parameter  int LEN_W     = 12,
   parameter  int TS_W      = 40,
   localparam int PW        = $clog2(PRE_DEPTH)
) (
   input  logic              CLK,
   input  logic              RESET,
   adc_trig_capture_if.slave bus,
   input  logic [1:0]        mode,
   input  logic              ext_trig,
   input  logic [DW-1:0]     thresh,
   input  logic [NCH-1:0]    trig_mask,
   input  logic [PW-1:0]     pre_len,
   input  logic [LEN_W-1:0]  win_len,
   input  logic [TS_W-1:0]   time_in,
   output logic              busy,
   output logic              overflow,
   output logic [15:0]       miss_cnt
);
   typedef enum logic [1:0] {IDLE, FILL, ARMED, CAPTURE} state_t;
   state_t            state_q, state_d;
   logic [NCH*DW-1:0] dl_q [PRE_DEPTH];
   logic [DW-1:0]     prev_q [NCH];
   logic              prev_ok_q;
   logic [PW-1:0]     pre_q, pre_d, fill_q, fill_d;
   logic [LEN_W:0]    rem_q, rem_d, total;
   logic [TS_W-1:0]   ts_q, ts_d;
   logic [15:0]       miss_q, miss_d;
   logic              ovf_q, ovf_d;
   logic [NCH*DW-1:0] data_q, data_d, tap;
   logic              valid_q, valid_d, first_q, first_d, last_q, last_d;
   logic              thr_hit, trig, rearm, emit, is_first, is_last;
   always_comb begin
      thr_hit = 1'b0;
      for (int c = 0; c < NCH; c++)
         thr_hit |= trig_mask[c] & prev_ok_q & (prev_q[c] < thresh) & (bus.adc_data[c*DW +: DW] >= thresh);
      trig = bus.adc_valid & ((mode[0] & ext_trig) | (mode[1] & thr_hit));
      tap = (pre_q == '0) ? bus.adc_data : dl_q[pre_q - 1'b1];
      total = (LEN_W+1)'(pre_q) + ((win_len == '0) ? (LEN_W+1)'(1) : (LEN_W+1)'(win_len));
      // the cycle after the final sample doubles as the re-arm point, so back-to-back events lose no sample
      rearm = (state_q == ARMED) | ((state_q == CAPTURE) & (rem_q == '0));
      state_d = state_q;
      pre_d = pre_q;
      fill_d = fill_q;
      rem_d = rem_q;
      ts_d = ts_q;
      miss_d = miss_q;
      emit = 1'b0;
      is_first = 1'b0;
      is_last = 1'b0;
      if (state_q == IDLE && mode != 2'd0) begin
         state_d = FILL;
         pre_d = pre_len;
         fill_d = '0;
      end
      if (state_q == FILL)
         if (fill_q == pre_q) state_d = ARMED;
         else if (bus.adc_valid) fill_d = fill_q + 1'b1;
      if (state_q == CAPTURE && !rearm) begin
         if (trig && miss_q != 16'hFFFF) miss_d = miss_q + 1'b1;
         emit = bus.adc_valid;
         is_last = rem_q == (LEN_W+1)'(1);
         if (bus.adc_valid) rem_d = rem_q - 1'b1;
      end
      if (rearm) begin
         state_d = (mode == 2'd0) ? IDLE : trig ? CAPTURE : ARMED;
         if (mode != 2'd0 && trig) begin
            ts_d = time_in;
            emit = 1'b1;
            is_first = 1'b1;
            is_last = total == (LEN_W+1)'(1);
            rem_d = total - 1'b1;
         end
      end
      valid_d = emit & ~bus.fifo_full;
      first_d = is_first & valid_d;
      last_d = is_last & valid_d;
      data_d = valid_d ? tap : data_q;
      ovf_d = ovf_q | (emit & bus.fifo_full);
   end
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= IDLE;
         pre_q <= '0;
         fill_q <= '0;
         rem_q <= '0;
         ts_q <= '0;
         miss_q <= '0;
         ovf_q <= 1'b0;
         data_q <= '0;
         valid_q <= 1'b0;
         first_q <= 1'b0;
         last_q <= 1'b0;
         prev_ok_q <= 1'b0;
         for (int i = 0; i < PRE_DEPTH; i++) dl_q[i] <= '0;
         for (int c = 0; c < NCH; c++) prev_q[c] <= '0;
      end else begin
         state_q <= state_d;
         pre_q <= pre_d;
         fill_q <= fill_d;
         rem_q <= rem_d;
         ts_q <= ts_d;
         miss_q <= miss_d;
         ovf_q <= ovf_d;
         data_q <= data_d;
         valid_q <= valid_d;
         first_q <= first_d;
         last_q <= last_d;
         if (bus.adc_valid) begin
            dl_q[0] <= bus.adc_data;
            for (int i = 1; i < PRE_DEPTH; i++) dl_q[i] <= dl_q[i-1];
            for (int c = 0; c < NCH; c++) prev_q[c] <= bus.adc_data[c*DW +: DW];
            prev_ok_q <= 1'b1;
         end
      end
   end
   assign bus.out_data = data_q;
   assign bus.out_valid = valid_q;
   assign bus.out_first = first_q;
   assign bus.out_last = last_q;
   assign bus.out_ts = ts_q;
   assign busy = state_q == CAPTURE;
   assign overflow = ovf_q;
   assign miss_cnt = miss_q;
endmodule

// File: tb/tb_adc_trig_capture.sv
// tb_adc_trig_capture: directed table-driven capture scenarios plus threshold, miss and reset sequences.
module tb_adc_trig_capture;
   localparam int NCH = 2, DW = 14, TS_W = 40;
   logic CLK = 1'b0, RESET = 1'b1;
   logic [1:0] mode = '0;
   logic ext_trig = 1'b0;
   logic [DW-1:0] thresh = '0;
   logic [NCH-1:0] trig_mask = '0;
   logic [3:0] pre_len = '0;
   logic [11:0] win_len = '0;
   logic [TS_W-1:0] time_in = '0;
   logic busy, overflow;
   logic [15:0] miss_cnt;
   int checks = 0, failures = 0;
   int nv, nf, nl, nb, f0, l0, f1, l1, lane_err, stray;
   typedef struct {
      int pre, win, trig, ff_lo, ff_hi;
      int nv, nf, nl, f0, l0, nb, ovf;
   } vec_t;
   vec_t tv [7];
   adc_trig_capture_if #(.NCH(NCH), .DW(DW), .TS_W(TS_W)) bus ();
   adc_trig_capture dut (
      .CLK(CLK), .RESET(RESET), .bus(bus), .mode(mode), .ext_trig(ext_trig),
      .thresh(thresh), .trig_mask(trig_mask), .pre_len(pre_len), .win_len(win_len),
      .time_in(time_in), .busy(busy), .overflow(overflow), .miss_cnt(miss_cnt)
   );
   always #5 CLK = ~CLK;
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic clr();
      nv = 0; nf = 0; nl = 0; nb = 0; lane_err = 0; stray = 0;
      f0 = -1; l0 = -1; f1 = -1; l1 = -1;
   endtask
   task automatic step(input logic v, input logic et, input logic ff, input int a0, input int a1);
      int d0, d1;
      bus.adc_valid = v;
      ext_trig = et;
      bus.fifo_full = ff;
      bus.adc_data = {DW'(a1), DW'(a0)};
      time_in = TS_W'(5000 + a0);
      @(posedge CLK);
      @(negedge CLK);
      if ((bus.out_first | bus.out_last) & ~bus.out_valid) stray++;
      if (bus.out_valid) begin
         nv++;
         d0 = int'(bus.out_data[DW-1:0]);
         d1 = int'(bus.out_data[NCH*DW-1:DW]);
         if (d1 != d0 + 2000) lane_err++;
         if (bus.out_first) begin nf++; f0 = d0; f1 = d1; end
         if (bus.out_last) begin nl++; l0 = d0; l1 = d1; end
      end
      if (busy) nb++;
   endtask
   task automatic do_reset();
      bus.adc_valid = 1'b0;
      ext_trig = 1'b0;
      bus.fifo_full = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
   endtask
   initial begin
      tv[0] = '{0, 1023,  20, -1, -1, 1023, 1, 1,  20, 1042, 1023, 0};
      tv[1] = '{4,    8, 100, -1, -1,   12, 1, 1,  96,  107,   12, 0};
      tv[2] = '{15,   0,  35, -1, -1,   16, 1, 1,  20,   35,   16, 0};
      tv[3] = '{0,    0,  30, -1, -1,    1, 1, 1,  30,   30,    1, 0};
      tv[4] = '{0,   16,  40, 45, 46,   14, 1, 1,  40,   55,   16, 1};
      tv[5] = '{0,    4,  40, 40, 40,    3, 0, 1,  -1,   43,    4, 1};
      tv[6] = '{3,    5,  50, 57, 57,    7, 1, 0,  47,   -1,    8, 1};
      bus.adc_data = '0;
      bus.adc_valid = 1'b0;
      bus.fifo_full = 1'b0;
      do_reset();
      chk("rst_flags", longint'({bus.out_valid, bus.out_first, bus.out_last, busy, overflow}), 0);
      chk("rst_data", longint'(bus.out_data), 0);
      chk("rst_ts", longint'(bus.out_ts), 0);
      chk("rst_miss", longint'(miss_cnt), 0);
      for (int k = 0; k < 7; k++) begin
         mode = 2'd1;
         pre_len = 4'(tv[k].pre);
         win_len = 12'(tv[k].win);
         do_reset();
         clr();
         for (int n = 0; n <= tv[k].trig + tv[k].pre + tv[k].win + 6; n++)
            step(1'b1, n == tv[k].trig, n >= tv[k].ff_lo && n <= tv[k].ff_hi, n, n + 2000);
         chk($sformatf("v%0d_count", k), nv, tv[k].nv);
         chk($sformatf("v%0d_nfirst", k), nf, tv[k].nf);
         chk($sformatf("v%0d_nlast", k), nl, tv[k].nl);
         if (tv[k].f0 >= 0) chk($sformatf("v%0d_first_data", k), f0, tv[k].f0);
         if (tv[k].l0 >= 0) chk($sformatf("v%0d_last_data", k), l0, tv[k].l0);
         chk($sformatf("v%0d_busy_cycles", k), nb, tv[k].nb);
         chk($sformatf("v%0d_overflow", k), longint'(overflow), tv[k].ovf);
         chk($sformatf("v%0d_ts", k), longint'(bus.out_ts), 5000 + tv[k].trig);
         chk($sformatf("v%0d_lane_stray", k), lane_err + stray, 0);
         chk($sformatf("v%0d_miss", k), longint'(miss_cnt), 0);
      end
      // threshold trigger on ch1 only
      mode = 2'd2; thresh = 14'd500; trig_mask = 2'b10; pre_len = 4'd0; win_len = 12'd4;
      do_reset();
      clr();
      for (int i = 0; i <= 20; i++) step(1'b1, 1'b0, 1'b0, 490 + i, 100);
      chk("thr_ch0_masked", nv, 0);
      clr();
      for (int i = 0; i <= 20; i++) step(1'b1, 1'b0, 1'b0, i, 490 + i);
      chk("thr_count", nv, 4);
      chk("thr_first", f1, 500);
      chk("thr_last", l1, 503);
      chk("thr_ts", longint'(bus.out_ts), 5010);
      clr();
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 0, 600);
      chk("thr_held_no_retrig", nv, 0);
      clr();
      step(1'b1, 1'b0, 1'b0, 0, 490);
      step(1'b0, 1'b0, 1'b0, 0, 510);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 0, 520);
      chk("thr_invalid_ignored_cnt", nv, 4);
      chk("thr_invalid_ignored_first", f1, 520);
      do_reset();
      clr();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 0, 600);
      chk("thr_first_sample_no_trig", nv, 0);
      mode = 2'd0;
      do_reset();
      clr();
      for (int n = 0; n < 12; n++) step(1'b1, n == 6, 1'b0, n, n + 2000);
      chk("mode_off_no_event", nv + nb, 0);
      // missed trigger during capture, then immediate re-trigger after out_last
      mode = 2'd1; pre_len = 4'd0; win_len = 12'd8;
      do_reset();
      clr();
      for (int n = 0; n <= 17; n++) step(1'b1, n == 10 || n == 13, 1'b0, n, n + 2000);
      chk("miss_count", longint'(miss_cnt), 1);
      chk("miss_event_len", nv, 8);
      chk("miss_last_data", l0, 17);
      for (int n = 18; n <= 30; n++) step(1'b1, n == 18, 1'b0, n, n + 2000);
      chk("retrig_total", nv, 16);
      chk("retrig_last", l0, 25);
      chk("retrig_miss", longint'(miss_cnt), 1);
      chk("retrig_ts", longint'(bus.out_ts), 5018);
      // reset in the middle of a capture
      pre_len = 4'd3;
      do_reset();
      clr();
      for (int n = 0; n <= 23; n++) step(1'b1, n == 20, n == 21, n, n + 2000);
      chk("pre_rst_busy_ovf", longint'({busy, overflow}), 3);
      RESET = 1'b0;
      #1;
      chk("mid_rst_flags", longint'({bus.out_valid, bus.out_first, bus.out_last, busy, overflow}), 0);
      chk("mid_rst_data_ts", longint'(bus.out_data) | longint'(bus.out_ts), 0);
      chk("mid_rst_miss", longint'(miss_cnt), 0);
      @(negedge CLK);
      RESET = 1'b1;
      clr();
      for (int n = 0; n <= 25; n++) step(1'b1, n == 1 || n == 3 || n == 9, 1'b0, n, n + 2000);
      chk("refill_count", nv, 11);
      chk("refill_first", f0, 6);
      chk("refill_last", l0, 16);
      chk("refill_miss", longint'(miss_cnt), 0);
      chk("refill_ts", longint'(bus.out_ts), 5009);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/adc_trig_capture.md
Name: adc_trig_capture

Overview:
Multi-channel triggered waveform capture controller between ADC inputs and the readout DAT_FIFOs. It replaces the fixed 1023-sample, once-per-second write window with several configurable features:
- channel count, data width and window length set by parameters;
- programmable pre-trigger samples;
- selectable periodic/external or threshold-crossing trigger;
- a timestamp latched per event.
All channels share one sample clock, CLK.

Parameters:
NCH, 2, number of ADC channels captured in lockstep
DW, 14, ADC sample width per channel
PRE_DEPTH, 16, pre-trigger delay-line depth (power of 2); max pre_len = PRE_DEPTH-1
LEN_W, 12, width of win_len
TS_W, 40, timestamp width

Ports:
CLK  in  1  sample clock
RESET  in  1  asynchronous, active-low reset
adc_data  in  NCH*DW  channel c at bits [c*DW+DW-1:c*DW]
adc_valid  in  1  sample strobe; ignored when low
mode  in  2  0=off, 1=external trigger, 2=threshold trigger, 3=external OR threshold
ext_trig  in  1  external/periodic trigger strobe, level-sampled on valid samples
thresh  in  DW  unsigned threshold
trig_mask  in  NCH  channels enabled for threshold trigger
pre_len  in  log2(PRE_DEPTH)  pre-trigger samples
win_len  in  LEN_W  post-trigger samples, including the trigger sample
time_in  in  TS_W  free-running time counter
fifo_full  in  1  downstream FIFO full
out_data  out  NCH*DW  captured samples
out_valid  out  1  FIFO write strobe
out_first  out  1  first sample of an event
out_last  out  1  last sample of an event
out_ts  out  TS_W  time_in latched at the trigger sample
busy  out  1  high in CAPTURE
overflow  out  1  sticky: a sample was dropped on fifo_full
miss_cnt  out  16  saturating count of triggers ignored while busy

Behaviour:
- Reset (RESET low, async):
  - state=IDLE, delay line cleared.
  - All outputs 0, including out_ts, overflow and miss_cnt.
- Delay line:
  - Every adc_valid shifts all channels in.
  - The delayed tap d[n] = x[n-pre_len] (pre_len=0 gives d=x).
  - pre_len is sampled at the IDLE->FILL transition and held until the next IDLE.
- Threshold trigger:
  - Fires on a masked channel c with prev_c < thresh and cur_c >= thresh, on a valid sample.
  - prev_c is updated only on valid samples.
  - A threshold at or below the first sample does not trigger; a rising crossing is required.
- Trigger = mode-selected OR of ext_trig and the threshold hit, qualified by adc_valid.
- FSM:
  - IDLE: go to FILL when mode!=0; clear fill counter.
  - FILL: count valid samples; go to ARMED when count == pre_len (immediately if pre_len=0). Triggers in FILL are ignored and not counted.
  - ARMED:
    - On trigger, latch out_ts<=time_in and set remaining = pre_len + max(win_len,1).
    - Go to CAPTURE; the trigger sample itself is emitted.
    - mode==0 returns to IDLE.
  - CAPTURE:
    - Each valid sample emits d and decrements remaining.
    - Leave at remaining==0, going to ARMED if mode!=0, else IDLE. Re-arm needs no refill, because the delay line stays primed.
    - A mode change mid-capture takes effect only after the event ends.
- Event content: samples x[n0-pre_len] .. x[n0+win_len-1], where n0 is the trigger sample. Length is pre_len+win_len; win_len=0 is treated as 1.
- Output timing:
  - out_valid/out_data are registered, 1 CLK after the input adc_valid.
  - out_first on the first emitted sample and out_last on the last; both on the same cycle for a 1-sample event.
- Backpressure:
  - If fifo_full is high on a sample cycle in CAPTURE, out_valid is suppressed for that sample, overflow is set, and the counter still decrements, so the event keeps fixed timing.
  - out_first/out_last are not re-issued for dropped samples.
- Missed triggers: a trigger while in CAPTURE increments miss_cnt, saturating at 16'hFFFF.
- busy = (state==CAPTURE).

Test Plan:
1. NCH=2, mode=1, pre_len=0, win_len=1023, one ext_trig pulse, adc_valid always high:
   - expect exactly 1023 out_valid, with first/last flagged;
   - out_ts = time_in at the trigger;
   - busy for 1023 cycles.
2. Ramp input x[n]=n, pre_len=4, win_len=8, ext_trig at n=100:
   - expect out_data values 96..107;
   - out_first with 96, out_last with 107.
3. mode=2, thresh=500, trig_mask=2'b10:
   - ch0 crossing 500 causes no event;
   - ch1 ramp 490→510 triggers an event at the first sample >=500;
   - ch1 held at 600 does not retrigger after re-arm.
4. ext_trig again at trigger+3 during CAPTURE:
   - miss_cnt=1;
   - the event length is unchanged;
   - the next trigger after out_last is accepted.
5. fifo_full high for 2 sample cycles mid-capture with win_len=16:
   - 14 out_valid pulses;
   - overflow=1 and stays set until reset.
6. RESET asserted mid-capture:
   - all outputs 0 immediately;
   - after release with mode=1, FILL must see pre_len samples before a trigger is accepted.
